// File: rtl/lded_stream.sv
// ---------------------------------------------------------------------------
// lded_stream
//
// Output-stage drain for the sorting engine. This block runs in the minor
// clock domain. A toggle on mj_level marks a new match vector from the major
// domain. The toggle is synchronised and the vector captured. The index of
// every set bit is then emitted, one per accepted valid/ready transfer. The
// scan starts from the low or the high end, as chosen by dir at load time.
//
// Optional feature: define LDED_LDCNT_EN to register the popcount of each
// loaded vector on ld_cnt. When it is undefined, ld_cnt is tied to zero.
//
// Ports
//   clk_mn    : minor clock. All logic runs on its rising edge.
//   rst       : synchronous, active-high reset.
//   mode      : 1 = sorting-output mode. 0 ignores loads and freezes a drain.
//   mj_level  : level toggled by the major domain when FO_mj_reg is stable.
//   FO_mj_reg : match vector, ELEMENT_NUM bits.
//   dir       : 0 = lowest index first, 1 = highest first. Sampled at load.
//   out_ready : consumer accepts out_addr.
//   out_valid : out_addr holds a pending index.
//   out_addr  : index of the current element.
//   out_last  : the current element is the final set bit of the vector.
//   TR_empty  : no elements pending. Registered, sent to the major domain.
//   overrun   : sticky flag. A load arrived while a drain was in progress.
//   ld_cnt    : popcount of the last loaded vector. Zero if the option is off.
// ---------------------------------------------------------------------------
module lded_stream #(
    parameter int ELEMENT_NUM = 16,
    localparam int AW = $clog2(ELEMENT_NUM)
) (
    input  logic                   clk_mn,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   mj_level,
    input  logic [ELEMENT_NUM-1:0] FO_mj_reg,
    input  logic                   dir,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [AW-1:0]          out_addr,
    output logic                   out_last,
    output logic                   TR_empty,
    output logic                   overrun,
    output logic [AW:0]            ld_cnt
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                 state, nxt_state;
    logic [2:0]             sync;
    logic [1:0]             guard;
    logic                   pulse;
    logic [ELEMENT_NUM-1:0] temp_reg, nxt_temp, clr_mask;
    logic                   dir_q, nxt_dir;
    logic                   tr_empty_q, nxt_empty;
    logic                   overrun_q, nxt_ovr;
    logic [AW-1:0]          addr_q;
    logic                   last_q;
    logic                   fire, load;

    // Returns the lowest set index, or the highest when hi is set.
    function automatic logic [AW-1:0] pick(input logic [ELEMENT_NUM-1:0] v,
                                           input logic hi);
        logic [AW-1:0] r;
        r = '0;
        if (hi) begin
            for (int i = 0; i < ELEMENT_NUM; i++)
                if (v[i]) r = i[AW-1:0];
        end else begin
            for (int i = ELEMENT_NUM - 1; i >= 0; i--)
                if (v[i]) r = i[AW-1:0];
        end
        return r;
    endfunction

    // The synchroniser carries no reset. After reset the guard counter hides
    // its contents until three clean samples have flushed through it.
    always_ff @(posedge clk_mn)
        sync <= {sync[1:0], mj_level};

    always_ff @(posedge clk_mn)
        if (rst)
            guard <= 2'd0;
        else if (guard != 2'd3)
            guard <= guard + 2'd1;

    assign pulse = (sync[1] ^ sync[2]) && (guard == 2'd3);

    // The outputs decode only registered state. mode gates out_valid.
    assign out_valid = (state == DRAIN) && mode;
    assign out_addr  = out_valid ? addr_q : '0;
    assign out_last  = out_valid && last_q;
    assign TR_empty  = tr_empty_q;
    assign overrun   = overrun_q;

    assign fire = out_valid && out_ready;
    // A load may overlap the final transfer of the previous vector.
    assign load = pulse && mode && ((state == IDLE) || (fire && last_q));

    always_comb begin
        nxt_state = state;
        nxt_temp  = temp_reg;
        nxt_dir   = dir_q;
        nxt_empty = tr_empty_q;
        nxt_ovr   = overrun_q;
        clr_mask  = '0;
        clr_mask[addr_q] = 1'b1;
        if (fire) begin
            nxt_temp = temp_reg & ~clr_mask;
            if (last_q) begin
                nxt_state = IDLE;
                nxt_empty = 1'b1;
            end
        end
        if (load) begin
            nxt_temp  = FO_mj_reg;
            nxt_dir   = dir;
            nxt_state = (FO_mj_reg != '0) ? DRAIN : IDLE;
            nxt_empty = (FO_mj_reg == '0);
        end else if (pulse && mode && state == DRAIN) begin
            nxt_ovr = 1'b1;
        end
    end

    // The address and last flag are pre-decoded from the next vector. This
    // keeps the priority encoder off the output path.
    always_ff @(posedge clk_mn) begin
        if (rst) begin
            state      <= IDLE;
            temp_reg   <= '0;
            dir_q      <= 1'b0;
            tr_empty_q <= 1'b1;
            overrun_q  <= 1'b0;
            addr_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state      <= nxt_state;
            temp_reg   <= nxt_temp;
            dir_q      <= nxt_dir;
            tr_empty_q <= nxt_empty;
            overrun_q  <= nxt_ovr;
            addr_q     <= pick(nxt_temp, nxt_dir);
            last_q     <= $onehot(nxt_temp);
        end
    end

`ifdef LDED_LDCNT_EN
    function automatic logic [AW:0] popcount(input logic [ELEMENT_NUM-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < ELEMENT_NUM; i++)
            c = c + {{AW{1'b0}}, v[i]};
        return c;
    endfunction

    logic [AW:0] ld_cnt_q;

    // Every accepted load updates the count, including an all-zero vector.
    always_ff @(posedge clk_mn)
        if (rst)
            ld_cnt_q <= '0;
        else if (load)
            ld_cnt_q <= popcount(FO_mj_reg);

    assign ld_cnt = ld_cnt_q;
`else
    assign ld_cnt = '0;
`endif

endmodule

// File: tb/tb_lded_stream.sv
module tb_lded_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        mj_level;
    logic [15:0] fo;
    logic        dir;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_addr;
    logic        out_last;
    logic        tr_empty;
    logic        overrun;
    logic [4:0]  ld_cnt;

    logic        mj32;
    logic [31:0] fo32;
    logic        valid32;
    logic [4:0]  addr32;
    logic        last32;
    logic        empty32;
    logic        ovr32;
    logic [5:0]  cnt32;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    lded_stream #(.ELEMENT_NUM(16)) dut (
        .clk_mn(clk), .rst(rst), .mode(mode), .mj_level(mj_level),
        .FO_mj_reg(fo), .dir(dir), .out_ready(out_ready),
        .out_valid(out_valid), .out_addr(out_addr), .out_last(out_last),
        .TR_empty(tr_empty), .overrun(overrun), .ld_cnt(ld_cnt)
    );

    lded_stream #(.ELEMENT_NUM(32)) dut32 (
        .clk_mn(clk), .rst(rst), .mode(1'b1), .mj_level(mj32),
        .FO_mj_reg(fo32), .dir(1'b1), .out_ready(1'b1),
        .out_valid(valid32), .out_addr(addr32), .out_last(last32),
        .TR_empty(empty32), .overrun(ovr32), .ld_cnt(cnt32)
    );

    task automatic checkOutput(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a queue of the indices still owed to the consumer.
    // A toggle seen at a sampling edge turns into a load two edges later,
    // unless reset happened fewer than three edges earlier.
    int   exp_q[$];
    bit   m_ovr = 0;
    int   m_ld = 0;
    int   since_rst = 0;
    int   cd = 0;
    logic last_lvl = 1'b0;

    always @(posedge clk) begin
        bit fire, pulse;
        fire  = mode && (exp_q.size() > 0) && out_ready;
        pulse = (cd == 1) && (since_rst >= 3);
        if (cd > 0) cd--;
        if (mj_level != last_lvl) cd = 2;
        last_lvl = mj_level;
        if (rst) begin
            exp_q.delete();
            m_ovr = 0;
            m_ld = 0;
            since_rst = 0;
        end else begin
            if (fire) void'(exp_q.pop_front());
            if (pulse && mode) begin
                if (exp_q.size() == 0) begin
                    for (int i = 0; i < 16; i++)
                        if (fo[i]) begin
                            if (dir) exp_q.push_front(i);
                            else exp_q.push_back(i);
                        end
                    m_ld = $countones(fo);
                end else begin
                    m_ovr = 1;
                end
            end
            if (since_rst < 3) since_rst++;
        end
    end

    int fire_log[$];
    int last_log[$];

    always @(negedge clk) begin
        bit v;
        int exp_cnt;
        if (chk_en) begin
            v = mode && (exp_q.size() > 0);
`ifdef LDED_LDCNT_EN
            exp_cnt = m_ld;
`else
            exp_cnt = 0;
`endif
            checkOutput("out_valid", out_valid, v);
            checkOutput("out_addr", out_addr, v ? exp_q[0] : 0);
            checkOutput("out_last", out_last, v && exp_q.size() == 1);
            checkOutput("TR_empty", tr_empty, exp_q.size() == 0);
            checkOutput("overrun", overrun, m_ovr);
            checkOutput("ld_cnt", ld_cnt, exp_cnt);
            if (out_valid && out_ready) begin
                fire_log.push_back(out_addr);
                last_log.push_back(out_last);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] vec, input logic d);
        fo = vec;
        dir = d;
        mj_level = ~mj_level;
    endtask

    task automatic checkLog(input string name, input int expv[$], input int lastmask);
        checkOutput({name, "_len"}, fire_log.size(), expv.size());
        for (int i = 0; i < expv.size() && i < fire_log.size(); i++) begin
            checkOutput({name, "_addr"}, fire_log[i], expv[i]);
            checkOutput({name, "_last"}, last_log[i], (lastmask >> i) & 1);
        end
        fire_log.delete();
        last_log.delete();
    endtask

    initial begin
        int e[$];
        rst = 1; mode = 1; mj_level = 0; fo = '0; dir = 0; out_ready = 1;
        mj32 = 0; fo32 = '0;
        tick(1);
        chk_en = 1;
        tick(2);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_empty", tr_empty, 1);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_ldcnt", ld_cnt, 0);
        rst = 0;
        tick(4);

        // Basic ascending drain
        fire_log.delete(); last_log.delete();
        applyStimulus(16'h8421, 0);
        tick(3);
        checkOutput("basic_first_addr", out_addr, 0);
        tick(5);
        e = '{0, 5, 10, 15};
        checkLog("basic", e, 4'b1000);
        checkOutput("basic_empty", tr_empty, 1);
`ifdef LDED_LDCNT_EN
        checkOutput("basic_ldcnt", ld_cnt, 4);
`endif

        // Descending drain with backpressure
        out_ready = 0;
        applyStimulus(16'h0013, 1);
        tick(3);
        checkOutput("bp_first_addr", out_addr, 4);
        out_ready = 1; tick(1);
        out_ready = 0; tick(1);
        checkOutput("bp_hold_addr", out_addr, 1);
        out_ready = 1; tick(1);
        out_ready = 0; tick(1);
        out_ready = 1; tick(3);
        e = '{4, 1, 0};
        checkLog("bp", e, 3'b100);

        // Zero vector
        applyStimulus(16'h0000, 0);
        tick(6);
        checkOutput("zero_valid", out_valid, 0);
        checkOutput("zero_empty", tr_empty, 1);
        checkOutput("zero_overrun", overrun, 0);
        checkOutput("zero_log", fire_log.size(), 0);

        // Second toggle lands on the final transfer of the first vector
        applyStimulus(16'h000F, 0);
        tick(4);
        applyStimulus(16'h0A00, 1);
        tick(10);
        e = '{0, 1, 2, 3, 11, 9};
        checkLog("align", e, 6'b101000);
        checkOutput("align_overrun", overrun, 0);

        // mode low freezes a drain in progress
        applyStimulus(16'h0030, 0);
        tick(3);
        mode = 0;
        tick(3);
        checkOutput("freeze_valid", out_valid, 0);
        mode = 1;
        tick(4);
        e = '{4, 5};
        checkLog("freeze", e, 2'b10);

        // Overrun: a load arrives during a stalled drain
        out_ready = 0;
        applyStimulus(16'h00F0, 0);
        tick(4);
        applyStimulus(16'h0F00, 0);
        tick(4);
        checkOutput("ovr_flag", overrun, 1);
        out_ready = 1;
        tick(6);
        e = '{4, 5, 6, 7};
        checkLog("ovr", e, 4'b1000);

        // Reset mid-drain with a toggle held across it
        applyStimulus(16'hFFFF, 0);
        tick(6);
        rst = 1;
        mj_level = ~mj_level;
        tick(1);
        checkOutput("rstmid_valid", out_valid, 0);
        checkOutput("rstmid_empty", tr_empty, 1);
        rst = 0;
        fire_log.delete(); last_log.delete();
        tick(8);
        checkOutput("rstmid_noload", fire_log.size(), 0);
        checkOutput("rstmid_overrun", overrun, 0);

        // 32-wide instance, descending
        fo32 = 32'h8000_0001;
        mj32 = ~mj32;
        tick(3);
        checkOutput("w32_valid0", valid32, 1);
        checkOutput("w32_addr0", addr32, 31);
        checkOutput("w32_last0", last32, 0);
        tick(1);
        checkOutput("w32_addr1", addr32, 0);
        checkOutput("w32_last1", last32, 1);
        tick(1);
        checkOutput("w32_valid2", valid32, 0);
        checkOutput("w32_empty2", empty32, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lded_stream.md
# lded_stream

Parametrised largest/duplicate-element drain for the sorting engine's output stage, in the minor clock domain. Captures an N-bit match vector from the major domain on a toggle of `mj_level`, then emits the index of every set bit, one per accepted valid/ready transfer, scanning from either end. It replaces the fixed 16-element decoder with a generic priority encoder. It adds backpressure, a last-element flag, direction control, overrun detection and an optional loaded-count output.

## Interface
- `ELEMENT_NUM`, 16: match vector width, ≥2.
- `AW`, $clog2(ELEMENT_NUM): index width; derived, not overridden.
- `clk_mn` input 1: minor clock. All logic is on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `mode` input 1: 1 = sorting-output mode. When 0, loads are ignored and an in-progress drain freezes; state is held and `out_valid` is forced to 0.
- `mj_level` input 1: level toggled by the major domain once `FO_mj_reg` is stable.
- `FO_mj_reg` input ELEMENT_NUM: match vector. Stable for ≥4 `clk_mn` cycles after each `mj_level` toggle.
- `dir` input 1: 0 = lowest index first, 1 = highest index first. Sampled at load.
- `out_ready` input 1: consumer accepts `out_addr`.
- `out_valid` output 1: `out_addr` is valid.
- `out_addr` output AW: index of the current element.
- `out_last` output 1: the current element is the final set bit of the loaded vector.
- `TR_empty` output 1: no elements pending. Registered and sent to the major domain.
- `overrun` output 1: sticky flag. A load arrived while a drain was in progress.
- `ld_cnt` output AW+1: popcount of the last loaded vector. See Configuration.

## Operation
- Synchroniser:
  - `sync[0..2]` shift `mj_level`.
  - `pulse = sync[1] ^ sync[2]`, qualified by `guard_done`.
  - `sync` stages are not reset.
  - On `rst`, a 2-bit guard counter clears. `pulse` is masked until the counter saturates at 3, which is 3 cycles after `rst` deasserts.
- FSM states: IDLE, DRAIN.
  - IDLE:
    - On `pulse && mode`, load `Temp_Reg <= FO_mj_reg` and `dir_q <= dir`.
    - If the loaded vector is non-zero, go to DRAIN and set `TR_empty <= 0`.
    - If it is zero, stay in IDLE with `TR_empty` = 1.
  - DRAIN:
    - `out_valid = mode`.
    - `out_addr` = lowest set index of `Temp_Reg` if `dir_q == 0`, else the highest.
    - `out_last` = `Temp_Reg` is one-hot.
    - On fire (`out_valid && out_ready`), clear bit `out_addr` in `Temp_Reg`.
    - If `out_last` fires, go to IDLE with `TR_empty <= 1`.
- Pulse during DRAIN, not on the last fire: the new vector is discarded, `overrun <= 1`, and the drain continues unchanged.
- Pulse on the same edge as a last fire: the new vector is loaded exactly as from IDLE. `overrun` is unchanged.
- `out_addr` and `out_last` are 0 whenever `out_valid` = 0.
- Reset values:
  - `Temp_Reg`, `dir_q`, `overrun`, `ld_cnt`, `out_valid`, `out_addr`, `out_last` = 0.
  - `TR_empty` = 1.
  - State = IDLE.
- Reset mid-drain discards all pending elements. `out_valid` is 0 in the cycle after the reset edge.

## Timing
- `mj_level` toggles before edge k:
  - `sync[0]` updates at k, `sync[1]` at k+1, `sync[2]` at k+2.
  - `pulse` is high during cycle k+1→k+2.
  - The load happens at edge k+2.
  - `out_valid` is first high after k+2.
- Load-to-first-valid latency is 3 `clk_mn` edges from the first sampling edge.
- With `out_ready` held high, throughput is one element per cycle. A vector with M set bits drains in M cycles.
- `out_addr`, `out_last` and `out_valid` are decoded from registers only. There is no combinational path from `out_ready` or `FO_mj_reg` to any output.
- `TR_empty` rises on the edge that accepts the last element.
- `overrun` rises on the edge of the discarded load.

## Configuration
- `LDED_LDCNT_EN` defined:
  - At every accepted load (including a zero vector), `ld_cnt <= popcount(FO_mj_reg)`, range 0..ELEMENT_NUM.
  - The value is held until the next load or `rst`.
- `LDED_LDCNT_EN` undefined: `ld_cnt` is tied to 0 and no popcount logic is synthesised. The port still exists.

## Test plan
- Basic drain: N=16, `FO_mj_reg`=16'h8421, `dir`=0, `out_ready`=1, toggle `mj_level` → `out_addr` 0, 5, 10, 15 on consecutive cycles. `out_last` only on 15. `TR_empty` returns to 1 after 15. With `LDED_LDCNT_EN`, `ld_cnt`=4.
- Direction and backpressure: vector 16'h0013, `dir`=1, `out_ready` toggling 1,0,1,0,1 → sequence 4, 1, 0. Each index is held stable while `out_ready`=0.
- Zero vector: load 16'h0000 → `out_valid` stays 0, `TR_empty` stays 1, `overrun` stays 0.
- Overrun and back-to-back:
  - Load 16'h00F0 with `out_ready`=0, then toggle again → `overrun`=1 and the drain still yields 4, 5, 6, 7.
  - Toggle aligned to the last fire → the second vector loads and `overrun` is unchanged.
- Reset mid-drain: load 16'hFFFF, accept 3 elements, pulse `rst` → next cycle `out_valid`=0 and `TR_empty`=1. A `mj_level`=1 level held across reset produces no load.
- Width: ELEMENT_NUM=32, vector 32'h8000_0001, `dir`=1 → `out_addr` 31 then 0, `out_last` on 0.
